// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and elaboration checks for the up/down counter
//
// Purpose: direction and end-of-range mode encodings, plus a parameter
// sanity check evaluated at elaboration time.
// Ports: none (package).
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // True when the width is usable and the reset value is representable in it.
  function automatic bit counter_params_ok(input int width, input longint reset_value);
    longint max_value;
    max_value = (longint'(1) << width) - 1;
    return (width >= 2) && (width <= 62) && (reset_value >= 0) && (reset_value <= max_value);
  endfunction

endpackage

// File: rtl/counter_step.sv
// rtl/counter_step.sv - combinational single-step rule for the up/down counter
//
// Purpose: given the current count, direction, terminal value and mode,
// produce the count after one enabled step and whether a boundary was hit.
// Ports:
//   count_i        current count
//   dir_i          1 = up, 0 = down
//   max_i          terminal value; range is 0..max_i
//   saturate_i     1 = saturate at the boundary, 0 = wrap
//   next_count_o   count after one enabled step
//   boundary_hit_o step wrapped or hit a saturated boundary
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             saturate_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             boundary_hit_o
);

  dir_e  dir;
  mode_e mode;

  assign dir  = dir_e'(dir_i);
  assign mode = mode_e'(saturate_i);

  always_comb begin
    next_count_o   = count_i;
    boundary_hit_o = 1'b0;
    if (dir == DIR_UP) begin
      // ">=" also catches a count stranded above a freshly lowered max.
      if (count_i >= max_i) begin
        boundary_hit_o = 1'b1;
        next_count_o   = (mode == MODE_SAT) ? max_i : '0;
      end else begin
        next_count_o = count_i + WIDTH'(1);
      end
    end else begin
      if (count_i > max_i) begin
        // Max was lowered under us: pull back into range without an event.
        next_count_o = max_i;
      end else if (count_i == '0) begin
        boundary_hit_o = 1'b1;
        next_count_o   = (mode == MODE_SAT) ? '0 : max_i;
      end else begin
        next_count_o = count_i - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - up/down counter with runtime modulus, wrap/saturate, load and clear
//
// Purpose: registered count over 0..i_max with clear > load > enable priority,
// terminal-count flag, one-cycle boundary event and sticky overflow.
// Ports:
//   i_clk, i_rst_n  clock (posedge) and asynchronous active-low reset
//   i_en            count enable
//   i_clear         synchronous clear to 0
//   i_load          synchronous load of i_load_value (clamped to i_max)
//   i_load_value    load data
//   i_dir           1 = up, 0 = down
//   i_max           terminal value
//   i_saturate      1 = saturate, 0 = wrap
//   i_ovf_clr       clears o_ovf (a same-cycle boundary hit wins)
//   o_count         registered count
//   o_tc            combinational terminal count for the current direction
//   o_event         registered pulse the cycle after a boundary hit
//   o_ovf           sticky boundary-hit flag
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_max,
  input  logic             i_saturate,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_event,
  output logic             o_ovf
);

  if (!counter_params_ok(WIDTH, longint'(RESET_VALUE))) begin : g_bad_params
    $error("updown_counter: WIDTH must be >= 2 and RESET_VALUE must fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             event_q, event_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_count;
  logic             step_hit;
  logic             hit_taken;

  counter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .count_i       (count_q),
    .dir_i         (i_dir),
    .max_i         (i_max),
    .saturate_i    (i_saturate),
    .next_count_o  (step_count),
    .boundary_hit_o(step_hit)
  );

  always_comb begin
    count_d   = count_q;
    hit_taken = 1'b0;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = (i_load_value > i_max) ? i_max : i_load_value;
    end else if (i_en) begin
      count_d   = step_count;
      hit_taken = step_hit;
    end
    event_d = hit_taken;
    ovf_d   = hit_taken | (ovf_q & ~i_ovf_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= RESET_COUNT;
      event_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      event_q <= event_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_tc    = i_en & ((dir_e'(i_dir) == DIR_UP) ? (count_q >= i_max) : (count_q == '0));
  assign o_count = count_q;
  assign o_event = event_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - self-checking bench for updown_counter
module tb_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, clr = 1'b0, ld = 1'b0, dir = 1'b1, sat = 1'b0, oclr = 1'b0;
  logic [W-1:0] lv = '0, mx = 4'd5;

  logic [W-1:0] cnt0, cnt1;
  logic         tc0, tc1, ev0, ev1, ovf0, ovf1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state for instance 0 (reset 0) and instance 1 (reset 14).
  int m_cnt [2] = '{0, 14};
  bit m_evt [2] = '{0, 0};
  bit m_ovf [2] = '{0, 0};
  int m_rst [2] = '{0, 14};

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(W), .RESET_VALUE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clear(clr), .i_load(ld),
    .i_load_value(lv), .i_dir(dir), .i_max(mx), .i_saturate(sat), .i_ovf_clr(oclr),
    .o_count(cnt0), .o_tc(tc0), .o_event(ev0), .o_ovf(ovf0)
  );

  updown_counter #(.WIDTH(W), .RESET_VALUE(14)) dut_fr (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clear(clr), .i_load(ld),
    .i_load_value(lv), .i_dir(dir), .i_max(mx), .i_saturate(sat), .i_ovf_clr(oclr),
    .o_count(cnt1), .o_tc(tc1), .o_event(ev1), .o_ovf(ovf1)
  );

  // Range 0..m has m+1 values; a wrapping step is modular arithmetic on that ring.
  function automatic int model_next(int c, int m);
    int r;
    r = m + 1;
    if (clr) return 0;
    if (ld) return (int'(lv) < m) ? int'(lv) : m;
    if (!en) return c;
    if (dir) begin
      if (sat) return (c + 1 > m) ? m : c + 1;
      return (c > m) ? 0 : (c + 1) % r;
    end
    if (c > m) return m;
    if (sat) return (c > 0) ? c - 1 : 0;
    return (c + m) % r;
  endfunction

  function automatic bit model_hit(int c, int m);
    if (clr || ld || !en) return 1'b0;
    return dir ? (c >= m) : (c == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] <= m_rst[k];
        m_evt[k] <= 1'b0;
        m_ovf[k] <= 1'b0;
      end else begin
        m_cnt[k] <= model_next(m_cnt[k], int'(mx));
        m_evt[k] <= model_hit(m_cnt[k], int'(mx));
        m_ovf[k] <= model_hit(m_cnt[k], int'(mx)) | (m_ovf[k] & ~oclr);
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit exp_tc;
      exp_tc = en && (dir ? (m_cnt[k] >= int'(mx)) : (m_cnt[k] == 0));
      cmp($sformatf("model.count[%0d]", k), (k == 0) ? int'(cnt0) : int'(cnt1), m_cnt[k]);
      cmp($sformatf("model.tc[%0d]", k), (k == 0) ? int'(tc0) : int'(tc1), int'(exp_tc));
      cmp($sformatf("model.event[%0d]", k), (k == 0) ? int'(ev0) : int'(ev1), int'(m_evt[k]));
      cmp($sformatf("model.ovf[%0d]", k), (k == 0) ? int'(ovf0) : int'(ovf1), int'(m_ovf[k]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int up_cnt [7] = '{1, 2, 3, 4, 5, 0, 1};
    int dn_cnt [4] = '{1, 0, 0, 0};
    int dn_evt [4] = '{0, 0, 1, 1};
    int fr_cnt [3] = '{15, 0, 1};

    // Reset state, then up-count with wrap at i_max=5.
    tick();
    cmp("reset.count", int'(cnt0), 0);
    cmp("reset.event", int'(ev0), 0);
    cmp("reset.ovf", int'(ovf0), 0);
    cmp("reset.count_rv14", int'(cnt1), 14);
    rst_n = 1'b1; en = 1'b1; dir = 1'b1; mx = 4'd5;
    for (int i = 0; i < 7; i++) begin
      tick();
      cmp($sformatf("upwrap.count%0d", i), int'(cnt0), up_cnt[i]);
      if (i == 4) cmp("upwrap.tc_at5", int'(tc0), 1);
      if (i == 5) cmp("upwrap.event", int'(ev0), 1);
      if (i == 6) cmp("upwrap.event_gone", int'(ev0), 0);
    end
    cmp("upwrap.ovf", int'(ovf0), 1);

    // Down-saturate from 2, clearing ovf during the load.
    en = 1'b0; ld = 1'b1; lv = 4'd2; oclr = 1'b1;
    tick();
    cmp("dnsat.load", int'(cnt0), 2);
    cmp("dnsat.ovf_cleared", int'(ovf0), 0);
    ld = 1'b0; oclr = 1'b0; dir = 1'b0; sat = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp($sformatf("dnsat.count%0d", i), int'(cnt0), dn_cnt[i]);
      cmp($sformatf("dnsat.event%0d", i), int'(ev0), dn_evt[i]);
    end
    cmp("dnsat.ovf", int'(ovf0), 1);
    en = 1'b0; oclr = 1'b1;
    tick();
    cmp("dnsat.ovf_clr", int'(ovf0), 0);
    oclr = 1'b0;

    // Priority: clear beats load beats enable; load clamps to i_max.
    ld = 1'b1; lv = 4'd3;
    tick();
    clr = 1'b1; lv = 4'd7; en = 1'b1;
    tick();
    cmp("prio.clear", int'(cnt0), 0);
    clr = 1'b0; en = 1'b0; lv = 4'd9; mx = 4'd6;
    tick();
    cmp("prio.load_clamp", int'(cnt0), 6);

    // i_max lowered below the count.
    sat = 1'b0; mx = 4'd15; lv = 4'd12;
    tick();
    cmp("shrink.load12", int'(cnt0), 12);
    ld = 1'b0; mx = 4'd4; dir = 1'b1; en = 1'b1;
    tick();
    cmp("shrink.upwrap", int'(cnt0), 0);
    cmp("shrink.upwrap_event", int'(ev0), 1);
    en = 1'b0; mx = 4'd15; ld = 1'b1;
    tick();
    ld = 1'b0; mx = 4'd4; sat = 1'b1; en = 1'b1;
    tick();
    cmp("shrink.upsat", int'(cnt0), 4);
    cmp("shrink.upsat_event", int'(ev0), 1);
    en = 1'b0; mx = 4'd15; ld = 1'b1;
    tick();
    ld = 1'b0; mx = 4'd4; dir = 1'b0; en = 1'b1;
    tick();
    cmp("shrink.down", int'(cnt0), 4);
    cmp("shrink.down_event", int'(ev0), 0);

    // i_max = 0: every enabled step stays at 0 and hits the boundary.
    mx = 4'd0; sat = 1'b0; dir = 1'b1;
    tick();
    cmp("max0.up", int'(cnt0), 0);
    cmp("max0.up_event", int'(ev0), 1);
    dir = 1'b0;
    tick();
    cmp("max0.down", int'(cnt0), 0);
    cmp("max0.down_event", int'(ev0), 1);

    // Full range from RESET_VALUE=14.
    en = 1'b0; rst_n = 1'b0; mx = 4'd15; dir = 1'b1;
    tick();
    cmp("full.reset", int'(cnt1), 14);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp($sformatf("full.count%0d", i), int'(cnt1), fr_cnt[i]);
      cmp($sformatf("full.event%0d", i), int'(ev1), (i == 1) ? 1 : 0);
    end
    cmp("full.ovf", int'(ovf1), 1);

    // Asynchronous reset between edges while count=9 and event=1.
    en = 1'b0; mx = 4'd9; ld = 1'b1; lv = 4'd0;
    tick();
    ld = 1'b0; dir = 1'b0; en = 1'b1;
    tick();
    cmp("async.pre_count", int'(cnt0), 9);
    cmp("async.pre_event", int'(ev0), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("async.count", int'(cnt0), 0);
    cmp("async.event", int'(ev0), 0);
    cmp("async.ovf", int'(ovf0), 0);
    cmp("async.count_rv14", int'(cnt1), 14);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
